// File: rtl/add_station_if.sv
// Issue port, busy mask and common-data-bus signals of one add reservation station.
// master = issue unit / bus side, slave = the station itself.
interface add_station_if;
  logic       issue_valid;
  logic       issue_op;
  logic [8:0] issue_vj;
  logic [8:0] issue_vk;
  logic [2:0] issue_qj;
  logic [2:0] issue_qk;
  logic       issue_ready;
  logic [2:0] issue_tag;
  logic [2:0] add_full;
  logic       cdb_in_valid;
  logic [2:0] cdb_in_tag;
  logic [8:0] cdb_in_value;
  logic       cdb_out_valid;
  logic [2:0] cdb_out_tag;
  logic [8:0] cdb_out_value;
  logic       cdb_grant;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    output cdb_in_valid, cdb_in_tag, cdb_in_value, cdb_grant,
    input  issue_ready, issue_tag, add_full,
    input  cdb_out_valid, cdb_out_tag, cdb_out_value
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    input  cdb_in_valid, cdb_in_tag, cdb_in_value, cdb_grant,
    output issue_ready, issue_tag, add_full,
    output cdb_out_valid, cdb_out_tag, cdb_out_value
  );
endinterface

// File: rtl/add_station.sv
// Three-entry add/sub reservation station with one multi-cycle adder; result held on
// cdb_out until cdb_grant, issue accepted only when an entry is free (registered state).
module add_station #(
  parameter int ADD_LAT  = 2,
  parameter int TAG_BASE = 1
) (
  input logic          clk,
  input logic          rst,
  add_station_if.slave bus
);
  localparam logic [2:0] TAG0 = 3'(TAG_BASE);
  localparam logic [2:0] LAT  = 3'(ADD_LAT);

  typedef struct packed {
    logic [2:0] q;
    logic [8:0] v;
  } opnd_t;

  typedef struct packed {
    logic  busy;
    logic  disp;
    logic  op;
    opnd_t j;
    opnd_t k;
  } ent_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  ent_t       ent [3];
  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [1:0] cur;
  logic [8:0] result;

  logic [1:0] free_idx;
  logic [1:0] rdy_idx;
  logic       any_free;
  logic       any_rdy;
  logic       own_bcast;
  logic [2:0] own_tag;
  logic       accept;
  logic       dispatch;
  logic       expire;
  opnd_t      iss_j;
  opnd_t      iss_k;
  opnd_t      wk_j [3];
  opnd_t      wk_k [3];

  // A pending operand picks up whichever bus currently carries its producer tag.
  function automatic opnd_t snoop(
    input opnd_t      o,
    input logic       iv,
    input logic [2:0] it,
    input logic [8:0] ival,
    input logic       ov,
    input logic [2:0] ot,
    input logic [8:0] oval
  );
    opnd_t r;
    r = o;
    if (o.q != 3'd0) begin
      if (iv && o.q == it) begin
        r.q = 3'd0;
        r.v = ival;
      end else if (ov && o.q == ot) begin
        r.q = 3'd0;
        r.v = oval;
      end
    end
    return r;
  endfunction

  always_comb begin
    free_idx = 2'd0;
    any_free = 1'b0;
    rdy_idx  = 2'd0;
    any_rdy  = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (!ent[i].busy) begin
        free_idx = 2'(i);
        any_free = 1'b1;
      end
      if (ent[i].busy && !ent[i].disp && ent[i].j.q == 3'd0 && ent[i].k.q == 3'd0) begin
        rdy_idx = 2'(i);
        any_rdy = 1'b1;
      end
    end
  end

  assign own_tag   = TAG0 + {1'b0, cur};
  assign own_bcast = (state == S_DONE) && bus.cdb_grant;
  assign accept    = bus.issue_valid && any_free;
  assign dispatch  = (state == S_IDLE) && any_rdy;
  assign expire    = (state == S_EXEC) && (cnt == 3'd1);

  always_comb begin
    iss_j = snoop({bus.issue_qj, bus.issue_vj}, bus.cdb_in_valid, bus.cdb_in_tag,
                  bus.cdb_in_value, own_bcast, own_tag, result);
    iss_k = snoop({bus.issue_qk, bus.issue_vk}, bus.cdb_in_valid, bus.cdb_in_tag,
                  bus.cdb_in_value, own_bcast, own_tag, result);
    for (int i = 0; i < 3; i++) begin
      wk_j[i] = snoop(ent[i].j, bus.cdb_in_valid, bus.cdb_in_tag, bus.cdb_in_value,
                      own_bcast, own_tag, result);
      wk_k[i] = snoop(ent[i].k, bus.cdb_in_valid, bus.cdb_in_tag, bus.cdb_in_value,
                      own_bcast, own_tag, result);
    end
  end

  // Freeing (grant) and allocation never hit the same entry: allocation uses registered busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ent[i].j <= wk_j[i];
        ent[i].k <= wk_k[i];
        if (dispatch && rdy_idx == 2'(i)) ent[i].disp <= 1'b1;
        if (own_bcast && cur == 2'(i)) begin
          ent[i].busy <= 1'b0;
          ent[i].disp <= 1'b0;
        end
        if (accept && free_idx == 2'(i)) begin
          ent[i].busy <= 1'b1;
          ent[i].disp <= 1'b0;
          ent[i].op   <= bus.issue_op;
          ent[i].j    <= iss_j;
          ent[i].k    <= iss_k;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_rdy) state_nxt = S_EXEC;
      S_EXEC:  if (cnt == 3'd1) state_nxt = S_DONE;
      S_DONE:  if (bus.cdb_grant) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 3'd0;
      cur    <= 2'd0;
      result <= 9'd0;
    end else begin
      if (dispatch) begin
        cur <= rdy_idx;
        cnt <= LAT;
      end else if (state == S_EXEC) begin
        cnt <= cnt - 3'd1;
      end
      if (expire) begin
        result <= ent[cur].op ? (ent[cur].j.v - ent[cur].k.v) : (ent[cur].j.v + ent[cur].k.v);
      end
    end
  end

  always_comb begin
    bus.cdb_out_valid = 1'b0;
    bus.cdb_out_tag   = 3'd0;
    bus.cdb_out_value = 9'd0;
    if (state == S_DONE) begin
      bus.cdb_out_valid = 1'b1;
      bus.cdb_out_tag   = own_tag;
      bus.cdb_out_value = result;
    end
  end

  assign bus.issue_ready = any_free;
  assign bus.issue_tag   = any_free ? (TAG0 + {1'b0, free_idx}) : TAG0;
  assign bus.add_full    = {ent[2].busy, ent[1].busy, ent[0].busy};
endmodule

// File: tb/tb_add_station.sv
// Directed scenarios followed by randomized traffic against a tag-level scoreboard of the station.
module tb_add_station;
  localparam int ADD_LAT  = 2;
  localparam int TAG_BASE = 1;
  localparam int LAT_OUT  = ADD_LAT + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bit   m_busy [3];
  bit   m_op   [3];
  int   m_vj   [3];
  int   m_qj   [3];
  int   m_vk   [3];
  int   m_qk   [3];
  bit   prev_valid;
  bit   prev_grant;
  int   prev_tag;
  int   prev_val;

  always #5 clk = ~clk;

  add_station_if bus ();

  add_station #(.ADD_LAT(ADD_LAT), .TAG_BASE(TAG_BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic int alu(input bit op, input int a, input int b);
    return op ? ((a - b) & 511) : ((a + b) & 511);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_op     = 1'b0;
    bus.issue_vj     = 9'd0;
    bus.issue_vk     = 9'd0;
    bus.issue_qj     = 3'd0;
    bus.issue_qk     = 3'd0;
    bus.cdb_in_valid = 1'b0;
    bus.cdb_in_tag   = 3'd0;
    bus.cdb_in_value = 9'd0;
  endtask

  task automatic drive_issue(input bit op, input int vj, input int qj, input int vk, input int qk);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_vj    = 9'(vj);
    bus.issue_qj    = 3'(qj);
    bus.issue_vk    = 9'(vk);
    bus.issue_qk    = 3'(qk);
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!bus.cdb_out_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic single_op(input string name, input bit op, input int a, input int b);
    int n;
    bus.cdb_grant = 1'b1;
    chk({name, "_issue_tag"}, bus.issue_tag, TAG_BASE);
    drive_issue(op, a, 0, b, 0);
    step();
    bus.issue_valid = 1'b0;
    chk({name, "_busy"}, bus.add_full, 1);
    wait_out(n);
    chk({name, "_latency"}, n, LAT_OUT);
    chk({name, "_out_tag"}, bus.cdb_out_tag, TAG_BASE);
    chk({name, "_out_value"}, bus.cdb_out_value, alu(op, a, b));
    step();
    chk({name, "_freed"}, bus.add_full, 0);
    chk({name, "_out_clear"}, bus.cdb_out_valid, 0);
  endtask

  task automatic wake(inout int q, inout int v, input bit iv, input int it, input int ival,
                      input bit ob, input int ot, input int oval);
    if (q != 0) begin
      if (iv && q == it) begin
        v = ival;
        q = 0;
      end else if (ob && q == ot) begin
        v = oval;
        q = 0;
      end
    end
  endtask

  function automatic int pick_q();
    int r;
    int k;
    r = int'($urandom_range(3));
    if (r == 2) begin
      k = int'($urandom_range(2));
      return m_busy[k] ? TAG_BASE + k : 0;
    end
    if (r == 3) return 4 + int'($urandom_range(3));
    return 0;
  endfunction

  task automatic rand_cycle(input bit allow_issue);
    int  lowest;
    int  mask;
    bit  full;
    bit  live;
    bit  own_b;
    int  own_idx;
    int  cur_tag;
    int  cur_val;
    int  own_val;
    int  ij_q, ij_v, ik_q, ik_v;
    int  in_t, in_v;
    bit  in_b;
    mask   = 0;
    lowest = -1;
    for (int i = 2; i >= 0; i--) begin
      if (m_busy[i]) mask |= (1 << i);
      else lowest = i;
    end
    full = (lowest < 0);
    chk("rnd_full_mask", bus.add_full, mask);
    chk("rnd_ready", bus.issue_ready, !full);
    if (!full) chk("rnd_issue_tag", bus.issue_tag, TAG_BASE + lowest);
    if (prev_valid && !prev_grant)
      chk("rnd_out_hold", {bus.cdb_out_valid, bus.cdb_out_tag, bus.cdb_out_value},
          {1'b1, 3'(prev_tag), 9'(prev_val)});
    cur_tag = int'(bus.cdb_out_tag);
    cur_val = int'(bus.cdb_out_value);
    own_idx = cur_tag - TAG_BASE;
    live    = 1'b0;
    own_val = cur_val;
    if (bus.cdb_out_valid) begin
      if (own_idx >= 0 && own_idx < 3) begin
        live = m_busy[own_idx] && m_qj[own_idx] == 0 && m_qk[own_idx] == 0;
      end
      chk("rnd_out_live", live, 1);
      if (live) begin
        own_val = alu(m_op[own_idx], m_vj[own_idx], m_vk[own_idx]);
        chk("rnd_out_value", cur_val, own_val);
      end
    end else begin
      chk("rnd_out_idle", {bus.cdb_out_tag, bus.cdb_out_value}, 0);
    end

    ij_q = pick_q();
    ik_q = pick_q();
    ij_v = int'($urandom_range(511));
    ik_v = int'($urandom_range(511));
    drive_issue(1'($urandom_range(1)), ij_v, ij_q, ik_v, ik_q);
    bus.issue_valid  = allow_issue && ($urandom_range(2) != 0);
    in_b = ($urandom_range(2) == 0);
    in_t = 4 + int'($urandom_range(3));
    in_v = int'($urandom_range(511));
    bus.cdb_in_valid = in_b;
    bus.cdb_in_tag   = 3'(in_t);
    bus.cdb_in_value = 9'(in_v);
    bus.cdb_grant    = allow_issue ? 1'($urandom_range(1)) : 1'b1;

    own_b = bus.cdb_out_valid && bus.cdb_grant && live;
    wake(ij_q, ij_v, in_b, in_t, in_v, own_b, cur_tag, own_val);
    wake(ik_q, ik_v, in_b, in_t, in_v, own_b, cur_tag, own_val);
    for (int i = 0; i < 3; i++) begin
      if (m_busy[i]) begin
        wake(m_qj[i], m_vj[i], in_b, in_t, in_v, own_b, cur_tag, own_val);
        wake(m_qk[i], m_vk[i], in_b, in_t, in_v, own_b, cur_tag, own_val);
      end
    end
    if (own_b) m_busy[own_idx] = 1'b0;
    if (bus.issue_valid && !full) begin
      m_busy[lowest] = 1'b1;
      m_op[lowest]   = bus.issue_op;
      m_vj[lowest]   = ij_v;
      m_qj[lowest]   = ij_q;
      m_vk[lowest]   = ik_v;
      m_qk[lowest]   = ik_q;
    end
    prev_valid = bus.cdb_out_valid;
    prev_grant = bus.cdb_grant;
    prev_tag   = cur_tag;
    prev_val   = cur_val;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw;
    bit  left;
    rst = 1'b1;
    idle_inputs();
    bus.cdb_grant = 1'b0;
    prev_valid = 1'b0;
    prev_grant = 1'b0;
    prev_tag   = 0;
    prev_val   = 0;
    for (int i = 0; i < 3; i++) m_busy[i] = 1'b0;
    step();
    step();
    chk("rst_add_full", bus.add_full, 0);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_issue_tag", bus.issue_tag, TAG_BASE);
    chk("rst_out_valid", bus.cdb_out_valid, 0);
    chk("rst_out_tag", bus.cdb_out_tag, 0);
    chk("rst_out_value", bus.cdb_out_value, 0);
    rst = 1'b0;
    step();
    chk("post_rst_add_full", bus.add_full, 0);
    chk("post_rst_out_valid", bus.cdb_out_valid, 0);

    single_op("add", 1'b0, 5, 7);
    single_op("sub_wrap", 1'b1, 3, 5);
    single_op("add_wrap", 1'b0, 500, 20);

    // Operand waits on an external producer.
    bus.cdb_grant = 1'b1;
    drive_issue(1'b0, 0, 4, 20, 0);
    step();
    bus.issue_valid = 1'b0;
    chk("wait_busy", bus.add_full, 1);
    chk("wait_no_out1", bus.cdb_out_valid, 0);
    step();
    chk("wait_no_out2", bus.cdb_out_valid, 0);
    step();
    chk("wait_no_out3", bus.cdb_out_valid, 0);
    bus.cdb_in_valid = 1'b1;
    bus.cdb_in_tag   = 3'd4;
    bus.cdb_in_value = 9'd100;
    step();
    bus.cdb_in_valid = 1'b0;
    wait_out(n);
    chk("wait_latency", n, LAT_OUT);
    chk("wait_out_value", bus.cdb_out_value, 120);
    step();
    chk("wait_freed", bus.add_full, 0);

    // Fill all entries, refuse a fourth, hold the result without grant.
    bus.cdb_grant = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk("fill_ready", bus.issue_ready, 1);
      chk("fill_issue_tag", bus.issue_tag, TAG_BASE + t);
      drive_issue(1'b0, 10 * (t + 1), 0, t, 0);
      step();
    end
    bus.issue_valid = 1'b0;
    chk("full_mask", bus.add_full, 7);
    chk("full_not_ready", bus.issue_ready, 0);
    drive_issue(1'b0, 99, 0, 0, 0);
    step();
    bus.issue_valid = 1'b0;
    chk("full_ignored", bus.add_full, 7);
    wait_out(n);
    for (int s = 0; s < 3; s++) begin
      chk("hold_valid", bus.cdb_out_valid, 1);
      chk("hold_tag", bus.cdb_out_tag, TAG_BASE);
      chk("hold_value", bus.cdb_out_value, 10);
      step();
    end
    bus.cdb_grant = 1'b1;
    chk("grant_cycle_not_ready", bus.issue_ready, 0);
    step();
    chk("after_grant_mask", bus.add_full, 6);
    chk("after_grant_ready", bus.issue_ready, 1);
    chk("after_grant_tag", bus.issue_tag, TAG_BASE);
    wait_out(n);
    chk("drain_tag2", bus.cdb_out_tag, TAG_BASE + 1);
    chk("drain_val2", bus.cdb_out_value, 21);
    step();
    wait_out(n);
    chk("drain_tag3", bus.cdb_out_tag, TAG_BASE + 2);
    chk("drain_val3", bus.cdb_out_value, 32);
    step();
    chk("drain_empty", bus.add_full, 0);

    // Own broadcast wakes a dependent entry.
    bus.cdb_grant = 1'b0;
    drive_issue(1'b0, 1, 0, 2, 0);
    step();
    chk("dep_issue_tag", bus.issue_tag, TAG_BASE + 1);
    drive_issue(1'b0, 0, TAG_BASE, 10, 0);
    step();
    bus.issue_valid = 1'b0;
    wait_out(n);
    chk("dep_first_tag", bus.cdb_out_tag, TAG_BASE);
    chk("dep_first_val", bus.cdb_out_value, 3);
    chk("dep_both_busy", bus.add_full, 3);
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
    wait_out(n);
    chk("dep_latency", n, LAT_OUT);
    chk("dep_second_tag", bus.cdb_out_tag, TAG_BASE + 1);
    chk("dep_second_val", bus.cdb_out_value, 13);
    bus.cdb_grant = 1'b1;
    step();
    chk("dep_empty", bus.add_full, 0);

    // Reset in the middle of execution.
    drive_issue(1'b0, 4, 0, 4, 0);
    step();
    bus.issue_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_add_full", bus.add_full, 0);
    chk("mid_rst_ready", bus.issue_ready, 1);
    chk("mid_rst_tag", bus.issue_tag, TAG_BASE);
    chk("mid_rst_out", {bus.cdb_out_valid, bus.cdb_out_tag, bus.cdb_out_value}, 0);
    step();
    rst = 1'b0;
    saw = 1'b0;
    for (int s = 0; s < 10; s++) begin
      saw |= bus.cdb_out_valid;
      step();
    end
    chk("mid_rst_no_result", saw, 0);
    chk("mid_rst_empty", bus.add_full, 0);

    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    left = 1'b1;
    for (int c = 0; c < 400 && left; c++) begin
      rand_cycle(1'b0);
      left = m_busy[0] || m_busy[1] || m_busy[2];
    end
    idle_inputs();
    chk("rnd_drained", left, 0);
    chk("rnd_final_mask", bus.add_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add_station.md
ADD_STATION -- requirements
Module: add_station

Interface
REQ-001 The block SHALL have parameter ADD_LAT, default 2: execute cycles from dispatch to result valid (legal 1..7).
REQ-002 The block SHALL have parameter TAG_BASE, default 1: tag of entry 0; entries 1 and 2 use TAG_BASE+1 and TAG_BASE+2; tag 0 means "operand ready".
REQ-003 The block SHALL have clock  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have issue_valid  input  1  the issue unit presents an instruction this cycle.
REQ-006 The block SHALL have issue_op  input  1  0 = add, 1 = subtract (Vj - Vk).
REQ-007 The block SHALL have issue_vj, issue_vk  input  9 each  operand values, meaningful when the matching Q is 0.
REQ-008 The block SHALL have issue_qj, issue_qk  input  3 each  producer tags, 0 = value present.
REQ-009 The block SHALL have issue_ready  output  1  at least one entry is free.
REQ-010 The block SHALL have issue_tag  output  3  tag of the entry the next accepted issue takes.
REQ-011 The block SHALL have add_full  output  3  busy mask, bit i = entry i.
REQ-012 The block SHALL have cdb_in_valid, cdb_in_tag (3), cdb_in_value (9)  input  result broadcasts from other units.
REQ-013 The block SHALL have cdb_out_valid, cdb_out_tag (3), cdb_out_value (9)  output  this unit's result broadcast.
REQ-014 The block SHALL have cdb_grant  input  1  the bus arbiter accepts cdb_out this cycle.

Function
REQ-015 Issue acceptance SHALL be issue_valid && issue_ready; the accepting entry SHALL be the lowest-index free entry; issue_tag SHALL be TAG_BASE + that index.
REQ-016 issue_ready and issue_tag SHALL be derived from registered busy state only; an entry freed this cycle SHALL NOT be reused until the next cycle.
REQ-017 The entry SHALL capture op, Vj/Qj and Vk/Qk; if an incoming Q matches a valid CDB tag (in or own-granted out) in the same cycle, the entry SHALL store the bus value with Q = 0.
REQ-018 Every cycle, each busy entry with Q matching a valid broadcast tag SHALL load the value and clear Q; both buses SHALL be snooped.
REQ-019 The single adder SHALL be an FSM: IDLE -> EXEC (ADD_LAT cycles) -> DONE -> IDLE.
REQ-020 IDLE: the lowest-index busy, not-dispatched entry with Qj = Qk = 0 (registered state) SHALL be dispatched; the FSM enters EXEC.
REQ-021 EXEC SHALL count down from ADD_LAT; at expiry it SHALL latch the 9-bit result (modulo 512, wraps with no flag) and enter DONE.
REQ-022 DONE SHALL hold cdb_out_valid = 1 with stable tag/value until cdb_grant; on grant the entry SHALL be freed and the FSM SHALL return to IDLE.
REQ-023 When cdb_out_valid = 0, cdb_out_tag and cdb_out_value SHALL be 0.
REQ-024 An entry SHALL NOT be dispatched twice; a dispatched entry SHALL stay busy until its grant.
REQ-025 issue_valid while not issue_ready SHALL be ignored with no state change.
REQ-026 cdb_grant outside DONE SHALL be ignored.
REQ-027 A CDB tag not held by any entry SHALL cause no state change.

Reset
REQ-028 On reset assertion, all entries, the FSM, and the counter SHALL clear immediately, including mid-EXEC or mid-DONE; in-flight results SHALL be discarded.
REQ-029 During and after reset: add_full = 000, issue_ready = 1, issue_tag = TAG_BASE, cdb_out_valid = 0, cdb_out_tag = 0, cdb_out_value = 0, FSM = IDLE.

Verification
REQ-030 Issue add with Vj=5, Vk=7, Q=0, and grant tied high -> tag 1 issued, cdb_out_valid after 1+ADD_LAT+1 cycles with tag 1, value 12; add_full returns to 000.
REQ-031 Issue sub with Vj=3, Vk=5 -> value 510 (wrap).
REQ-032 Issue with Qj=4, then cdb_in tag 4 value 100 three cycles later -> no dispatch before that broadcast, result equals 100 op Vk.
REQ-033 Issue 3 entries, then a 4th -> issue_ready = 0 and the 4th is ignored; hold grant low -> cdb_out stays stable; grant -> entry 0 frees, issue_ready = 1 the next cycle.
REQ-034 Entry 1 waits on tag 1 (entry 0) -> the own granted broadcast wakes entry 1, which dispatches in the following cycle.
REQ-035 Assert reset during EXEC -> all outputs are at reset values immediately, and no cdb_out_valid appears afterwards.
